// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG coefficient rebuild path.
package jpeg_pkg;

  typedef enum logic [2:0] {
    DC_SYM,
    DC_AMP,
    AC_SYM,
    AC_AMP,
    ZRUN,
    FILL
  } state_t;

  localparam logic [7:0] EOB      = 8'h00;
  localparam logic [7:0] ZRL      = 8'hF0;
  localparam logic [5:0] LAST_IDX = 6'd63;
  localparam logic [3:0] MAX_S    = 4'd11;

  // Sizes above 11 cannot carry a 12-bit coefficient, so they are pinned to the maximum.
  function automatic logic [3:0] clamp_size(input logic [3:0] s);
    return (s > MAX_S) ? MAX_S : s;
  endfunction

endpackage

// File: rtl/amplitude_extend.sv
// Turns the s raw amplitude bits that follow a JPEG code into a signed coefficient.
module amplitude_extend #(
  parameter int COEF_W = 12
) (
  input  logic [10:0]              raw,
  input  logic [3:0]               s,
  output logic signed [COEF_W-1:0] value
);

  logic [10:0] mask;
  logic [10:0] top_bit;
  logic [10:0] magnitude;
  logic        positive;

  // A leading 1 means the bits are the value itself; a leading 0 means value = raw - (2^s - 1).
  always_comb begin
    mask      = ~(11'h7FF << s);
    top_bit   = mask & ~(mask >> 1);
    magnitude = raw & mask;
    positive  = |(magnitude & top_bit);
    if (positive) begin
      value = COEF_W'(magnitude);
    end else begin
      value = COEF_W'(magnitude) - COEF_W'(mask);
    end
  end

endmodule

// File: rtl/rle_coefficient_decoder.sv
// Rebuilds one 8x8 block of zig-zag coefficients from Huffman (run, size) symbols and amplitude bits.
module rle_coefficient_decoder
  import jpeg_pkg::*;
#(
  parameter int COEF_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     next_bit,
  input  logic                     is_new,
  output logic                     bit_ready,
  output logic                     amp_phase,
  output logic                     ac_dc_flag,
  input  logic                     hd_done,
  input  logic [3:0]               hd_r,
  input  logic [3:0]               hd_s,
  output logic                     coef_valid,
  output logic signed [COEF_W-1:0] coef_value,
  output logic [5:0]               coef_index,
  output logic                     block_done,
  output logic                     err
);

  state_t                   state, state_n;
  logic [5:0]               idx, idx_n;
  logic [4:0]               run_cnt, run_n;
  logic                     run_amp, run_amp_n;
  logic [3:0]               s_reg, s_n;
  logic [9:0]               raw, raw_n;
  logic [3:0]               bit_cnt, bit_cnt_n;
  logic signed [COEF_W-1:0] pred, pred_n;
  logic                     err_n;
  logic                     valid_n, done_n;
  logic signed [COEF_W-1:0] value_n;
  logic [5:0]               index_n;
  logic                     awake;

  logic [10:0]              raw_shift;
  logic signed [COEF_W-1:0] amp_value;
  logic [3:0]               s_in;
  logic [5:0]               next_idx;
  logic                     take_bit;
  logic                     last_bit;

  assign raw_shift = {raw, next_bit};
  assign s_in      = clamp_size(hd_s);
  assign next_idx  = idx + 6'd1;
  assign last_bit  = ((bit_cnt + 4'd1) == s_reg);
  assign take_bit  = is_new && bit_ready;

  // The block holds off bits for one cycle after reset so every output reads quiet then.
  assign bit_ready  = awake && (state == DC_SYM || state == AC_SYM ||
                                state == DC_AMP || state == AC_AMP);
  assign amp_phase  = (state == DC_AMP) || (state == AC_AMP);
  assign ac_dc_flag = (state == DC_SYM) || (state == DC_AMP);

  amplitude_extend #(.COEF_W(COEF_W)) u_extend (
    .raw   (raw_shift),
    .s     (s_reg),
    .value (amp_value)
  );

  // Next-state, datapath and registered-output decisions for every state.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    run_n     = run_cnt;
    run_amp_n = run_amp;
    s_n       = s_reg;
    raw_n     = raw;
    bit_cnt_n = bit_cnt;
    pred_n    = pred;
    err_n     = err;
    valid_n   = 1'b0;
    value_n   = '0;
    index_n   = '0;
    done_n    = 1'b0;
    case (state)
      DC_SYM: begin
        if (hd_done) begin
          s_n       = s_in;
          raw_n     = '0;
          bit_cnt_n = '0;
          if (s_in == 4'd0) begin
            valid_n = 1'b1;
            value_n = pred;
            idx_n   = '0;
            state_n = AC_SYM;
          end else begin
            state_n = DC_AMP;
          end
        end
      end
      DC_AMP: begin
        if (take_bit) begin
          raw_n     = raw_shift[9:0];
          bit_cnt_n = bit_cnt + 4'd1;
          if (last_bit) begin
            pred_n  = pred + amp_value;
            valid_n = 1'b1;
            value_n = pred + amp_value;
            idx_n   = '0;
            state_n = AC_SYM;
          end
        end
      end
      AC_SYM: begin
        if (hd_done) begin
          s_n       = s_in;
          raw_n     = '0;
          bit_cnt_n = '0;
          if ({hd_r, hd_s} == EOB) begin
            state_n = (idx == LAST_IDX) ? DC_SYM : FILL;
          end else if ({hd_r, hd_s} == ZRL || s_in == 4'd0) begin
            run_n     = {1'b0, hd_r} + 5'd1;
            run_amp_n = 1'b0;
            state_n   = ZRUN;
          end else if (hd_r != 4'd0) begin
            run_n     = {1'b0, hd_r};
            run_amp_n = 1'b1;
            state_n   = ZRUN;
          end else begin
            state_n = AC_AMP;
          end
        end
      end
      ZRUN: begin
        valid_n = 1'b1;
        index_n = next_idx;
        idx_n   = next_idx;
        run_n   = run_cnt - 5'd1;
        if (next_idx == LAST_IDX) begin
          done_n  = 1'b1;
          idx_n   = '0;
          state_n = DC_SYM;
          if (run_cnt > 5'd1 || run_amp) begin
            err_n = 1'b1;
          end
        end else if (run_cnt == 5'd1) begin
          state_n = run_amp ? AC_AMP : AC_SYM;
        end
      end
      AC_AMP: begin
        if (take_bit) begin
          raw_n     = raw_shift[9:0];
          bit_cnt_n = bit_cnt + 4'd1;
          if (last_bit) begin
            valid_n = 1'b1;
            value_n = amp_value;
            index_n = next_idx;
            idx_n   = next_idx;
            if (next_idx == LAST_IDX) begin
              done_n  = 1'b1;
              idx_n   = '0;
              state_n = DC_SYM;
            end else begin
              state_n = AC_SYM;
            end
          end
        end
      end
      FILL: begin
        valid_n = 1'b1;
        index_n = next_idx;
        idx_n   = next_idx;
        if (next_idx == LAST_IDX) begin
          done_n  = 1'b1;
          idx_n   = '0;
          state_n = DC_SYM;
        end
      end
      default: state_n = DC_SYM;
    endcase
  end

  // State, counters, predictor and the registered coefficient outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DC_SYM;
      idx        <= '0;
      run_cnt    <= '0;
      run_amp    <= 1'b0;
      s_reg      <= '0;
      raw        <= '0;
      bit_cnt    <= '0;
      pred       <= '0;
      err        <= 1'b0;
      coef_valid <= 1'b0;
      coef_value <= '0;
      coef_index <= '0;
      block_done <= 1'b0;
      awake      <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      run_cnt    <= run_n;
      run_amp    <= run_amp_n;
      s_reg      <= s_n;
      raw        <= raw_n;
      bit_cnt    <= bit_cnt_n;
      pred       <= pred_n;
      err        <= err_n;
      coef_valid <= valid_n;
      coef_value <= value_n;
      coef_index <= index_n;
      block_done <= done_n;
      awake      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rle_coefficient_decoder.sv
// Directed bench for rle_coefficient_decoder with hand-computed expected coefficients.
module tb_rle_coefficient_decoder;

  localparam int COEF_W = 12;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     next_bit = 1'b0;
  logic                     is_new = 1'b0;
  logic                     hd_done = 1'b0;
  logic [3:0]               hd_r = '0;
  logic [3:0]               hd_s = '0;
  logic                     bit_ready, amp_phase, ac_dc_flag;
  logic                     coef_valid, block_done, err;
  logic signed [COEF_W-1:0] coef_value;
  logic [5:0]               coef_index;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int vals[64];
  int valid_cnt, done_cnt, done_idx;
  int amp_low_cnt = 0;
  int done_before;

  rle_coefficient_decoder #(.COEF_W(COEF_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .next_bit   (next_bit),
    .is_new     (is_new),
    .bit_ready  (bit_ready),
    .amp_phase  (amp_phase),
    .ac_dc_flag (ac_dc_flag),
    .hd_done    (hd_done),
    .hd_r       (hd_r),
    .hd_s       (hd_s),
    .coef_valid (coef_valid),
    .coef_value (coef_value),
    .coef_index (coef_index),
    .block_done (block_done),
    .err        (err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Scoreboard: capture every emitted coefficient by its zig-zag index.
  always @(negedge clk) begin
    if (coef_valid) begin
      vals[coef_index] = coef_value;
      valid_cnt++;
      if (block_done) begin
        done_cnt++;
        done_idx = coef_index;
      end
    end
  end

  // Hard stop in case the sequence wedges somewhere unbounded.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_cnt++;
    if (observed == expected) pass_cnt++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic waitReady(input string tag);
    int guard = 0;
    while (!bit_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] r, input logic [3:0] s,
                               input logic [10:0] bits);
    waitReady(tag);
    hd_r    = r;
    hd_s    = s;
    hd_done = 1'b1;
    @(negedge clk);
    hd_done = 1'b0;
    for (int i = int'(s) - 1; i >= 0; i--) begin
      next_bit = bits[i];
      is_new   = 1'b1;
      waitReady(tag);
      if (!amp_phase) amp_low_cnt++;
      @(negedge clk);
    end
    is_new = 1'b0;
  endtask

  task automatic waitBlockDone(input string tag);
    int start = done_cnt;
    int guard = 0;
    while (done_cnt == start && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_done"}, done_cnt - start, 1);
  endtask

  task automatic clearScoreboard();
    for (int i = 0; i < 64; i++) vals[i] = 999;
    valid_cnt = 0;
    done_cnt  = 0;
    done_idx  = -1;
  endtask

  function automatic int countNonZero(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (vals[i] != 0) n++;
    return n;
  endfunction

  initial begin
    clearScoreboard();
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", coef_valid, 0);
    checkOutput("rst_done", block_done, 0);
    checkOutput("rst_ready", bit_ready, 0);
    checkOutput("rst_amp", amp_phase, 0);
    checkOutput("rst_flag", ac_dc_flag, 1);
    checkOutput("rst_err", err, 0);
    rst = 1'b0;

    // Block 1: DC s=3 bits 010 -> -5, AC (2,1) bit 1, EOB.
    applyStimulus("dc1", 4'd0, 4'd3, 11'b010);
    checkOutput("dc1_valid", coef_valid, 1);
    checkOutput("dc1_value", coef_value, -5);
    checkOutput("dc1_index", coef_index, 0);
    checkOutput("dc1_flag", ac_dc_flag, 0);
    applyStimulus("ac1", 4'd2, 4'd1, 11'b1);
    applyStimulus("eob1", 4'd0, 4'd0, 11'd0);
    waitBlockDone("blk1");
    checkOutput("blk1_v0", vals[0], -5);
    checkOutput("blk1_v1", vals[1], 0);
    checkOutput("blk1_v2", vals[2], 0);
    checkOutput("blk1_v3", vals[3], 1);
    checkOutput("blk1_fill_nonzero", countNonZero(4, 63), 0);
    checkOutput("blk1_count", valid_cnt, 64);
    checkOutput("blk1_done_idx", done_idx, 63);
    checkOutput("blk1_flag_after", ac_dc_flag, 1);

    // Block 2: DC s=2 bits 11 -> -2, three ZRLs, (0,4) bits 0111 -> -8 at 49, EOB.
    clearScoreboard();
    applyStimulus("dc2", 4'd0, 4'd2, 11'b11);
    checkOutput("dc2_value", coef_value, -2);
    checkOutput("dc2_index", coef_index, 0);
    applyStimulus("zrl_a", 4'd15, 4'd0, 11'd0);
    checkOutput("zrun_ready", bit_ready, 0);
    hd_r    = 4'd0;
    hd_s    = 4'd0;
    hd_done = 1'b1;
    @(negedge clk);
    hd_done = 1'b0;
    applyStimulus("zrl_b", 4'd15, 4'd0, 11'd0);
    applyStimulus("zrl_c", 4'd15, 4'd0, 11'd0);
    applyStimulus("ac2", 4'd0, 4'd4, 11'b0111);
    checkOutput("ac2_value", coef_value, -8);
    checkOutput("ac2_index", coef_index, 49);
    applyStimulus("eob2", 4'd0, 4'd0, 11'd0);
    waitBlockDone("blk2");
    checkOutput("blk2_v0", vals[0], -2);
    checkOutput("blk2_run_nonzero", countNonZero(1, 48), 0);
    checkOutput("blk2_v49", vals[49], -8);
    checkOutput("blk2_fill_nonzero", countNonZero(50, 63), 0);
    checkOutput("blk2_count", valid_cnt, 64);
    checkOutput("blk2_err", err, 0);

    // Block 3: DC s=0 keeps predictor -2, four ZRLs overflow past 63.
    clearScoreboard();
    applyStimulus("dc3", 4'd0, 4'd0, 11'd0);
    checkOutput("dc3_value", coef_value, -2);
    for (int k = 0; k < 4; k++) applyStimulus("zrl_ovf", 4'd15, 4'd0, 11'd0);
    waitBlockDone("blk3");
    checkOutput("ovf_err", err, 1);
    checkOutput("ovf_done_idx", done_idx, 63);
    checkOutput("ovf_count", valid_cnt, 64);
    checkOutput("ovf_nonzero", countNonZero(1, 63), 0);
    checkOutput("ovf_flag", ac_dc_flag, 1);
    applyStimulus("dc4", 4'd0, 4'd0, 11'd0);
    checkOutput("dc4_index", coef_index, 0);
    checkOutput("dc4_value", coef_value, -2);
    checkOutput("dc4_flag", ac_dc_flag, 0);
    checkOutput("err_sticky", err, 1);

    // Reset in the middle of a zero run, then decode a fresh block.
    applyStimulus("zrl_r", 4'd15, 4'd0, 11'd0);
    repeat (3) @(negedge clk);
    done_before = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_valid", coef_valid, 0);
    checkOutput("mid_rst_value", coef_value, 0);
    checkOutput("mid_rst_index", coef_index, 0);
    checkOutput("mid_rst_done", block_done, 0);
    checkOutput("mid_rst_ready", bit_ready, 0);
    checkOutput("mid_rst_amp", amp_phase, 0);
    checkOutput("mid_rst_flag", ac_dc_flag, 1);
    checkOutput("mid_rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_no_done", done_cnt, done_before);

    clearScoreboard();
    applyStimulus("dc5", 4'd0, 4'd3, 11'b010);
    checkOutput("dc5_value", coef_value, -5);
    applyStimulus("ac5", 4'd0, 4'd1, 11'b0);
    checkOutput("ac5_value", coef_value, -1);
    checkOutput("ac5_index", coef_index, 1);
    applyStimulus("eob5", 4'd0, 4'd0, 11'd0);
    waitBlockDone("blk5");
    checkOutput("blk5_count", valid_cnt, 64);
    checkOutput("blk5_v0", vals[0], -5);
    checkOutput("blk5_fill_nonzero", countNonZero(2, 63), 0);
    checkOutput("blk5_done_idx", done_idx, 63);
    checkOutput("amp_phase_low_on_bit", amp_low_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
